// File: rtl/aes_queue_pkg.sv
// Shared types for the AES block queue: scheduler states and input-queue entries.
package aes_queue_pkg;
    localparam int BLOCK_W = 128;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} sched_state_t;

    typedef struct packed {
        logic               op;
        logic [BLOCK_W-1:0] data;
    } q_entry_t;
endpackage

// File: rtl/aes_block_fifo.sv
// Circular-buffer FIFO with registered occupancy count; head is readable combinationally.
module aes_block_fifo #(
    parameter int W     = 128,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic [W-1:0]  data_i,
    input  logic          pop_i,
    output logic [W-1:0]  head_o,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          empty_o
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          push_ok, pop_ok;

    // Flags come from the registered count, so a push into a full queue is
    // refused even when the head leaves at the same edge.
    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CW'(push_ok) - CW'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= data_i;
    end
endmodule

// File: rtl/aes_block_queue.sv
// Host-side block assembler, input/output block queues and a one-in-flight
// scheduler that feeds the AES core through a start/busy/done handshake.
module aes_block_queue
    import aes_queue_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int LANES  = 128 / DATA_W,
    parameter int AW     = $clog2(LANES),
    parameter int CW     = $clog2(DEPTH) + 1
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [DATA_W-1:0]  DIN,
    input  logic [AW-1:0]      ADDR,
    input  logic               WR,
    input  logic               OP,
    input  logic               PUSH,
    input  logic               POP,
    output logic [DATA_W-1:0]  DOUT,
    output logic [CW-1:0]      IN_COUNT,
    output logic [CW-1:0]      OUT_COUNT,
    output logic               IN_FULL,
    output logic               OUT_EMPTY,
    output logic               ERR,
    output logic               core_start,
    output logic [BLOCK_W-1:0] core_text,
    output logic               core_op,
    input  logic               core_full,
    input  logic               core_done,
    input  logic [BLOCK_W-1:0] core_result
);
    sched_state_t       state_q, state_d;
    logic               err_q, err_d;
    wire  [BLOCK_W-1:0] asm_data;
    wire  [DATA_W-1:0]  out_lanes [LANES];
    q_entry_t           in_entry, in_head;
    logic [BLOCK_W-1:0] out_head;
    logic               in_empty, out_full;
    logic               issue, capture;

    // Lane 0 sits at the top of the block so it carries AES byte 0.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [DATA_W-1:0] lane_q;

        always_ff @(posedge CLK or posedge RST) begin
            if (RST)                            lane_q <= '0;
            else if (WR && (ADDR == AW'(gi)))   lane_q <= DIN;
        end

        assign asm_data[BLOCK_W-1-gi*DATA_W -: DATA_W]  = lane_q;
        assign out_lanes[gi] = out_head[BLOCK_W-1-gi*DATA_W -: DATA_W];
    end

    assign in_entry = {OP, asm_data};

    aes_block_fifo #(.W($bits(q_entry_t)), .DEPTH(DEPTH), .CW(CW)) u_in_q (
        .clk     (CLK),
        .rst     (RST),
        .push_i  (PUSH),
        .data_i  (in_entry),
        .pop_i   (issue),
        .head_o  (in_head),
        .count_o (IN_COUNT),
        .full_o  (IN_FULL),
        .empty_o (in_empty)
    );

    aes_block_fifo #(.W(BLOCK_W), .DEPTH(DEPTH), .CW(CW)) u_out_q (
        .clk     (CLK),
        .rst     (RST),
        .push_i  (capture),
        .data_i  (core_result),
        .pop_i   (POP),
        .head_o  (out_head),
        .count_o (OUT_COUNT),
        .full_o  (out_full),
        .empty_o (OUT_EMPTY)
    );

    // Issuing only while the output queue has room reserves a slot for the result.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!in_empty && !core_full && !out_full) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (core_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign issue   = (state_q == ISSUE);
    assign capture = (state_q == WAIT) && core_done;
    assign err_d   = err_q | (PUSH & IN_FULL) | (POP & OUT_EMPTY)
                   | (core_done & (state_q != WAIT));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    assign ERR        = err_q;
    assign core_start = issue;
    assign core_text  = issue ? in_head.data : '0;
    assign core_op    = issue && in_head.op;
    assign DOUT       = OUT_EMPTY ? '0 : out_lanes[ADDR];
endmodule

// File: tb/tb_aes_block_queue.sv
// Scoreboard bench: stimulus queues expected core issues and results; monitors check on core_start.
module tb_aes_block_queue;
    localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int iss8 = 0;
    int iss32 = 0;

    // DATA_W = 8 instance
    logic [7:0]   din8, dout8;
    logic [3:0]   addr8;
    logic         wr8, op8, push8, pop8;
    logic [2:0]   in_cnt8, out_cnt8;
    logic         in_full8, out_empty8, err8, start8, cop8;
    logic [127:0] ctext8, res8;
    logic         full8, done8, mdone8, busy8, force_full8, stray8;
    int           cnt8;

    // DATA_W = 32 instance
    logic [31:0]  din32, dout32;
    logic [1:0]   addr32;
    logic         wr32, op32, push32, pop32;
    logic [2:0]   in_cnt32, out_cnt32;
    logic         in_full32, out_empty32, err32, start32, cop32;
    logic [127:0] ctext32, res32;
    logic         full32, done32, mdone32, busy32;
    int           cnt32;

    aes_block_queue #(.DATA_W(8), .DEPTH(4)) u8 (
        .CLK(clk), .RST(rst), .DIN(din8), .ADDR(addr8), .WR(wr8), .OP(op8),
        .PUSH(push8), .POP(pop8), .DOUT(dout8), .IN_COUNT(in_cnt8),
        .OUT_COUNT(out_cnt8), .IN_FULL(in_full8), .OUT_EMPTY(out_empty8),
        .ERR(err8), .core_start(start8), .core_text(ctext8), .core_op(cop8),
        .core_full(full8), .core_done(done8), .core_result(res8)
    );

    aes_block_queue #(.DATA_W(32), .DEPTH(4)) u32 (
        .CLK(clk), .RST(rst), .DIN(din32), .ADDR(addr32), .WR(wr32), .OP(op32),
        .PUSH(push32), .POP(pop32), .DOUT(dout32), .IN_COUNT(in_cnt32),
        .OUT_COUNT(out_cnt32), .IN_FULL(in_full32), .OUT_EMPTY(out_empty32),
        .ERR(err32), .core_start(start32), .core_text(ctext32), .core_op(cop32),
        .core_full(full32), .core_done(done32), .core_result(res32)
    );

    function automatic logic [127:0] core_model(input logic [127:0] t);
        if (t == PT) return CT;
        return {t[63:0], t[127:64]};
    endfunction

    // Bench cores: result appears 10 cycles after the issue pulse.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            busy8 <= 1'b0; cnt8 <= 0; mdone8 <= 1'b0; res8 <= '0;
        end else begin
            mdone8 <= 1'b0;
            if (start8) begin
                busy8 <= 1'b1; cnt8 <= 10; res8 <= core_model(ctext8);
            end else if (busy8) begin
                cnt8 <= cnt8 - 1;
                if (cnt8 == 1) begin busy8 <= 1'b0; mdone8 <= 1'b1; end
            end
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            busy32 <= 1'b0; cnt32 <= 0; mdone32 <= 1'b0; res32 <= '0;
        end else begin
            mdone32 <= 1'b0;
            if (start32) begin
                busy32 <= 1'b1; cnt32 <= 10; res32 <= core_model(ctext32);
            end else if (busy32) begin
                cnt32 <= cnt32 - 1;
                if (cnt32 == 1) begin busy32 <= 1'b0; mdone32 <= 1'b1; end
            end
        end
    end

    assign done8  = mdone8 | stray8;
    assign full8  = busy8 | force_full8;
    assign done32 = mdone32;
    assign full32 = busy32;

    logic [128:0] exp_iss8[$], exp_iss32[$];
    logic [127:0] exp_out8[$], exp_out32[$];
    logic [127:0] asm8, asm32;
    logic [128:0] m_e8, m_e32;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (start8) begin
            iss8++;
            if (exp_iss8.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL issue8_unexpected: got op=%0d text=%h expected no issue", cop8, ctext8);
            end else begin
                m_e8 = exp_iss8.pop_front();
                chk("issue8_op", {127'd0, cop8}, {127'd0, m_e8[128]});
                chk("issue8_text", ctext8, m_e8[127:0]);
            end
        end
    end

    always @(negedge clk) begin
        if (start32) begin
            iss32++;
            if (exp_iss32.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL issue32_unexpected: got op=%0d text=%h expected no issue", cop32, ctext32);
            end else begin
                m_e32 = exp_iss32.pop_front();
                chk("issue32_op", {127'd0, cop32}, {127'd0, m_e32[128]});
                chk("issue32_text", ctext32, m_e32[127:0]);
            end
        end
    end

    task automatic wr_lane8(input int a, input logic [7:0] d);
        addr8 = a[3:0]; din8 = d; wr8 = 1'b1;
        @(posedge clk); #1;
        wr8 = 1'b0;
        asm8[127-a*8 -: 8] = d;
    endtask

    task automatic wr_lane32(input int a, input logic [31:0] d);
        addr32 = a[1:0]; din32 = d; wr32 = 1'b1;
        @(posedge clk); #1;
        wr32 = 1'b0;
        asm32[127-a*32 -: 32] = d;
    endtask

    task automatic push_blk8(input logic op, input bit keep_out);
        op8 = op; push8 = 1'b1;
        @(posedge clk); #1;
        push8 = 1'b0;
        exp_iss8.push_back({op, asm8});
        if (keep_out) exp_out8.push_back(core_model(asm8));
    endtask

    task automatic push_blk32(input logic op);
        op32 = op; push32 = 1'b1;
        @(posedge clk); #1;
        push32 = 1'b0;
        exp_iss32.push_back({op, asm32});
        exp_out32.push_back(core_model(asm32));
    endtask

    task automatic head_pop8(input string name);
        logic [127:0] b;
        for (int i = 0; i < 16; i++) begin
            addr8 = i[3:0]; #1;
            b[127-i*8 -: 8] = dout8;
        end
        chk(name, b, (exp_out8.size() > 0) ? exp_out8.pop_front() : 128'hx);
        pop8 = 1'b1;
        @(posedge clk); #1;
        pop8 = 1'b0;
    endtask

    task automatic head_pop32(input string name);
        logic [127:0] b;
        for (int i = 0; i < 4; i++) begin
            addr32 = i[1:0]; #1;
            b[127-i*32 -: 32] = dout32;
        end
        chk(name, b, (exp_out32.size() > 0) ? exp_out32.pop_front() : 128'hx);
        pop32 = 1'b1;
        @(posedge clk); #1;
        pop32 = 1'b0;
    endtask

    task automatic wait_out8(input logic [2:0] n, input string name);
        for (int k = 0; k < 400 && out_cnt8 != n; k++) begin
            @(posedge clk); #1;
        end
        chk(name, {125'd0, out_cnt8}, {125'd0, n});
    endtask

    task automatic wait_out32(input logic [2:0] n, input string name);
        for (int k = 0; k < 400 && out_cnt32 != n; k++) begin
            @(posedge clk); #1;
        end
        chk(name, {125'd0, out_cnt32}, {125'd0, n});
    endtask

    task automatic chk_reset8(input string p);
        chk({p, "_dout"},      {120'd0, dout8},      '0);
        chk({p, "_in_cnt"},    {125'd0, in_cnt8},    '0);
        chk({p, "_out_cnt"},   {125'd0, out_cnt8},   '0);
        chk({p, "_in_full"},   {127'd0, in_full8},   '0);
        chk({p, "_out_empty"}, {127'd0, out_empty8}, 128'd1);
        chk({p, "_err"},       {127'd0, err8},       '0);
        chk({p, "_start"},     {127'd0, start8},     '0);
        chk({p, "_text"},      ctext8,               '0);
        chk({p, "_op"},        {127'd0, cop8},       '0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int i0;
        rst = 1'b1;
        din8 = '0; addr8 = '0; wr8 = 0; op8 = 0; push8 = 0; pop8 = 0;
        din32 = '0; addr32 = '0; wr32 = 0; op32 = 0; push32 = 0; pop32 = 0;
        force_full8 = 0; stray8 = 0;
        asm8 = '0; asm32 = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_reset8("rst0");
        chk("rst0_u32_empty", {127'd0, out_empty32}, 128'd1);

        // 32-bit lanes: second block differs only in lane 3, ops 1 then 0
        wr_lane32(0, 32'h00112233);
        wr_lane32(1, 32'h44556677);
        wr_lane32(2, 32'h8899aabb);
        wr_lane32(3, 32'hccddeeff);
        push_blk32(1'b1);
        wr_lane32(3, 32'hdeadbeef);
        push_blk32(1'b0);
        wait_out32(3'd2, "u32_out_count");
        head_pop32("u32_block0");
        head_pop32("u32_block1");
        @(negedge clk);
        chk("u32_empty", {127'd0, out_empty32}, 128'd1);
        chk("u32_issues", iss32, 2);

        // Single block, issue latency and lane-wise readback
        for (int i = 0; i < 16; i++) wr_lane8(i, 8'(i * 17));
        push_blk8(1'b0, 1'b1);
        @(negedge clk);
        chk("t1_start_k0", {127'd0, start8}, '0);
        chk("t1_in_cnt", {125'd0, in_cnt8}, 128'd1);
        @(negedge clk);
        chk("t1_start_k1", {127'd0, start8}, 128'd1);
        @(negedge clk);
        chk("t1_in_popped", {125'd0, in_cnt8}, '0);
        wait_out8(3'd1, "t1_out_count");
        for (int i = 0; i < 16; i++) begin
            addr8 = i[3:0]; #1;
            chk($sformatf("t1_lane%0d", i), {120'd0, dout8}, {120'd0, CT[127-i*8 -: 8]});
        end
        pop8 = 1'b1; @(posedge clk); #1; pop8 = 1'b0;
        void'(exp_out8.pop_front());
        @(negedge clk);
        chk("t1_out_empty", {127'd0, out_empty8}, 128'd1);
        chk("t1_dout_empty", {120'd0, dout8}, '0);

        // Five back-to-back pushes into a depth-4 queue while the core is busy;
        // each push also rewrites lane 0 to show PUSH takes pre-write contents
        force_full8 = 1'b1;
        i0 = iss8;
        for (int j = 0; j < 5; j++) begin
            op8 = j[0]; push8 = 1'b1; wr8 = 1'b1; addr8 = 4'd0; din8 = 8'(8'hA0 + j);
            @(posedge clk); #1;
            if (j < 4) begin
                exp_iss8.push_back({j[0], asm8});
                exp_out8.push_back(core_model(asm8));
            end
            asm8[127:120] = 8'(8'hA0 + j);
        end
        push8 = 1'b0; wr8 = 1'b0;
        @(negedge clk);
        chk("t2_in_cnt", {125'd0, in_cnt8}, 128'd4);
        chk("t2_in_full", {127'd0, in_full8}, 128'd1);
        chk("t2_err", {127'd0, err8}, 128'd1);
        repeat (5) @(negedge clk);
        chk("t2_no_issue", iss8, i0);

        // Output back-pressure: fill the output queue, then one POP frees one issue
        force_full8 = 1'b0;
        wait_out8(3'd4, "t3_fill");
        chk("t3_in_drained", {125'd0, in_cnt8}, '0);
        chk("t3_issues", iss8, i0 + 4);
        wr_lane8(0, 8'h55);
        push_blk8(1'b1, 1'b1);
        repeat (30) @(negedge clk);
        chk("t3_stalled", iss8, i0 + 4);
        chk("t3_in_held", {125'd0, in_cnt8}, 128'd1);
        head_pop8("t3_head0");
        repeat (40) @(negedge clk);
        chk("t3_one_issue", iss8, i0 + 5);
        chk("t3_out_refill", {125'd0, out_cnt8}, 128'd4);
        chk("t3_in_empty", {125'd0, in_cnt8}, '0);
        for (int k = 1; k <= 4; k++) head_pop8($sformatf("t3_head%0d", k));
        @(negedge clk);
        chk("t3_drained", {127'd0, out_empty8}, 128'd1);

        // Reset while a block is in flight, then a stray core_done in IDLE
        wr_lane8(5, 8'h77);
        push_blk8(1'b0, 1'b0);
        for (int k = 0; k < 50 && iss8 < i0 + 6; k++) @(negedge clk);
        chk("t4_issued", iss8, i0 + 6);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        asm8 = '0;
        @(negedge clk);
        chk_reset8("rst1");
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("t4_err_clear", {127'd0, err8}, '0);
        stray8 = 1'b1; @(posedge clk); #1 stray8 = 1'b0;
        @(negedge clk);
        chk("t4_stray_err", {127'd0, err8}, 128'd1);
        chk("t4_no_capture", {125'd0, out_cnt8}, '0);
        repeat (15) @(negedge clk);
        chk("t4_no_issue", iss8, i0 + 6);

        chk("issue8_queue_drained", exp_iss8.size(), 0);
        chk("issue32_queue_drained", exp_iss32.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
